// File: rtl/sram_seq_pkg.sv
// Shared types and constants for the external async SRAM access sequencer.
package sram_seq_pkg;

    localparam int unsigned ADDR_W    = 18;
    localparam int unsigned ADDR_LO_W = 16;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned WAIT_W    = 4;

    // CTRL write bit positions
    localparam int unsigned CTRL_AUTOINC = 0;
    localparam int unsigned CTRL_A_LO    = 1;
    localparam int unsigned CTRL_A_HI    = 2;
    localparam int unsigned CTRL_FETCH   = 3;
    localparam int unsigned CTRL_CLR_ERR = 4;

    // STATUS read bit positions (AUTOINC and A17:A16 share the CTRL positions)
    localparam int unsigned STAT_ERR  = 4;
    localparam int unsigned STAT_BUSY = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_SETUP,
        ST_W_PULSE,
        ST_W_HOLD,
        ST_R_ACCESS,
        ST_R_SAMPLE
    } state_t;

    // Assemble the CTRL/STATUS read word
    function automatic logic [DATA_W-1:0] status_word(input logic busy, input logic err,
                                                      input logic [1:0] a_hi, input logic autoinc);
        status_word = '0;
        status_word[STAT_BUSY]              = busy;
        status_word[STAT_ERR]               = err;
        status_word[CTRL_A_HI:CTRL_A_LO]    = a_hi;
        status_word[CTRL_AUTOINC]           = autoinc;
    endfunction

endpackage

// File: rtl/sram_seq_if.sv
// CPU-side IO register bus between the j1 strobes and the SRAM sequencer.
interface sram_seq_if;
    import sram_seq_pkg::*;

    logic              io_wr;
    logic              io_rd;
    logic              sel_addr;
    logic              sel_data;
    logic              sel_ctrl;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;

    modport master (
        output io_wr, io_rd, sel_addr, sel_data, sel_ctrl, wd,
        input  rd
    );

    modport slave (
        input  io_wr, io_rd, sel_addr, sel_data, sel_ctrl, wd,
        output rd
    );

endinterface

// File: rtl/sram_seq.sv
// Timed write/read cycle generator for the 256K x 16 async SRAM with
// auto-increment addressing and a one-word read prefetch buffer.
module sram_seq
    import sram_seq_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    sram_seq_if.slave         bus,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ncs,
    output logic              sram_nwe,
    output logic              sram_noe
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                autoinc_q;
    logic                err_q;
    logic [DATA_W-1:0]   rbuf_q;

    logic                busy_c;
    logic                addr_wr_c;
    logic                ctrl_wr_c;
    logic                data_wr_c;
    logic                data_rd_c;
    logic                fetch_c;
    logic                clr_err_c;
    logic                collide_c;
    logic                start_wr_c;
    logic                start_rd_c;
    logic [DATA_W-1:0]   status_c;

    // Register-access decode and collision detection
    assign busy_c     = (state != ST_IDLE);
    assign addr_wr_c  = bus.io_wr & bus.sel_addr;
    assign ctrl_wr_c  = bus.io_wr & bus.sel_ctrl;
    assign data_wr_c  = bus.io_wr & bus.sel_data;
    assign data_rd_c  = bus.io_rd & bus.sel_data;
    assign fetch_c    = ctrl_wr_c & bus.wd[CTRL_FETCH];
    assign clr_err_c  = ctrl_wr_c & bus.wd[CTRL_CLR_ERR];
    assign collide_c  = busy_c & (data_wr_c | ctrl_wr_c | addr_wr_c | data_rd_c);
    assign start_wr_c = ~busy_c & data_wr_c;
    assign start_rd_c = ~busy_c & (fetch_c | (data_rd_c & autoinc_q));

    assign sram_a   = addr_q;
    assign status_c = status_word(busy_c, err_q, addr_q[ADDR_W-1:ADDR_LO_W], autoinc_q);

    // CPU read mux; zero when nothing is selected so the top can OR it in
    assign bus.rd = bus.sel_data ? rbuf_q :
                    bus.sel_ctrl ? status_c :
                    bus.sel_addr ? addr_q[ADDR_LO_W-1:0] : '0;

    // Access FSM with registered pad controls; strobes load the next state's pin levels
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            addr_q      <= '0;
            autoinc_q   <= 1'b0;
            err_q       <= 1'b0;
            rbuf_q      <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ncs    <= 1'b1;
            sram_nwe    <= 1'b1;
            sram_noe    <= 1'b1;
        end else begin
            // A collision in the same cycle as a clear wins
            err_q <= (err_q & ~clr_err_c) | collide_c;

            case (state)
                ST_IDLE: begin
                    if (addr_wr_c) begin
                        addr_q[ADDR_LO_W-1:0] <= bus.wd;
                    end
                    if (ctrl_wr_c) begin
                        autoinc_q                    <= bus.wd[CTRL_AUTOINC];
                        addr_q[ADDR_W-1:ADDR_LO_W]   <= bus.wd[CTRL_A_HI:CTRL_A_LO];
                    end
                    if (start_wr_c) begin
                        state       <= ST_W_SETUP;
                        sram_ncs    <= 1'b0;
                        sram_dq_oe  <= 1'b1;
                        sram_dq_out <= bus.wd;
                    end else if (start_rd_c) begin
                        state    <= ST_R_ACCESS;
                        sram_ncs <= 1'b0;
                        sram_noe <= 1'b0;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                ST_W_SETUP: begin
                    state    <= ST_W_PULSE;
                    sram_nwe <= 1'b0;
                    wait_cnt <= WAIT_LOAD;
                end
                ST_W_PULSE: begin
                    if (wait_cnt == '0) begin
                        state    <= ST_W_HOLD;
                        sram_nwe <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                ST_W_HOLD: begin
                    state      <= ST_IDLE;
                    sram_ncs   <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    if (autoinc_q) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                ST_R_ACCESS: begin
                    if (wait_cnt == '0) begin
                        state <= ST_R_SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                ST_R_SAMPLE: begin
                    state    <= ST_IDLE;
                    sram_ncs <= 1'b1;
                    sram_noe <= 1'b1;
                    rbuf_q   <= sram_dq_in;
                    if (autoinc_q) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    sram_ncs   <= 1'b1;
                    sram_nwe   <= 1'b1;
                    sram_noe   <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_seq.sv
// Bench for sram_seq: pin-level async SRAM model, transaction-level register
// model with per-cycle compare, and directed register-access scenarios.
module tb_sram_seq;
    import sram_seq_pkg::*;

    localparam int unsigned W     = 2;
    localparam int unsigned MEM_N = 262144;
    localparam logic [2:0]  SEL_NONE = 3'b000;
    localparam logic [2:0]  SEL_ADDR = 3'b001;
    localparam logic [2:0]  SEL_DATA = 3'b010;
    localparam logic [2:0]  SEL_CTRL = 3'b100;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] sram_a;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_ncs;
    logic        sram_nwe;
    logic        sram_noe;

    sram_seq_if bus_if();

    sram_seq #(.WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if.slave),
        .sram_a      (sram_a),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_ncs    (sram_ncs),
        .sram_nwe    (sram_nwe),
        .sram_noe    (sram_noe)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- pin-level async SRAM model ----------------
    logic [15:0] sram_mem [MEM_N];
    logic [15:0] exp_mem  [MEM_N];
    logic        rst_q = 1'b0;
    logic        prev_nwe = 1'b1;
    logic        prev_ncs = 1'b1;
    logic        saw_oe = 1'b0;
    int          nwe_lo = 0;
    int          ncs_lo = 0;
    int          last_run = 0;
    logic [17:0] wr_a;
    logic [15:0] wr_d;

    // Input pad register: captures the SRAM output while the chip drives it
    always @(posedge clk) begin
        sram_dq_in <= (!sram_ncs && !sram_noe) ? sram_mem[sram_a] : 16'h0000;
        rst_q      <= reset;
    end

    // Write commits on nWE rising only with data still held on the bus
    always @(negedge clk) begin
        check("oe_and_noe", 32'(sram_dq_oe & ~sram_noe), 32'd0);
        check("strobe_without_cs", 32'((~sram_nwe | ~sram_noe) & sram_ncs), 32'd0);
        if (!sram_nwe) begin
            nwe_lo++;
            wr_a = sram_a;
            wr_d = sram_dq_out;
        end else if (!prev_nwe) begin
            if (sram_dq_oe && !sram_ncs) begin
                check("nwe_width", 32'(nwe_lo), 32'(W));
                sram_mem[wr_a] = wr_d;
            end
            nwe_lo = 0;
        end
        if (!sram_ncs) begin
            ncs_lo++;
            if (sram_dq_oe) saw_oe = 1'b1;
        end else if (!prev_ncs) begin
            if (!rst_q) check("access_len", 32'(ncs_lo), saw_oe ? 32'(W + 2) : 32'(W + 1));
            last_run = ncs_lo;
            ncs_lo   = 0;
            saw_oe   = 1'b0;
        end
        prev_nwe = sram_nwe;
        prev_ncs = sram_ncs;
    end

    // ---------------- transaction-level register model ----------------
    logic        started = 1'b0;
    int          busy_left = 0;
    logic        m_is_wr;
    logic [15:0] m_wd;
    logic [17:0] m_addr;
    logic        m_autoinc;
    logic        m_err;
    logic [15:0] m_rbuf;
    logic        m_dwr, m_drd, m_awr, m_cwr;
    logic [15:0] m_in;

    always @(posedge clk) begin
        m_dwr = bus_if.io_wr & bus_if.sel_data;
        m_drd = bus_if.io_rd & bus_if.sel_data;
        m_awr = bus_if.io_wr & bus_if.sel_addr;
        m_cwr = bus_if.io_wr & bus_if.sel_ctrl;
        m_in  = bus_if.wd;
        if (reset) begin
            started   = 1'b1;
            busy_left = 0;
            m_addr    = '0;
            m_autoinc = 1'b0;
            m_err     = 1'b0;
            m_rbuf    = '0;
        end else if (started) begin
            if (busy_left > 0) begin
                if (m_dwr || m_drd || m_awr || m_cwr) m_err = 1'b1;
                busy_left--;
                if (busy_left == 0) begin
                    if (m_is_wr) exp_mem[m_addr] = m_wd;
                    else         m_rbuf = exp_mem[m_addr];
                    if (m_autoinc) m_addr = m_addr + 18'd1;
                end
            end else begin
                if (m_awr) m_addr[15:0] = m_in;
                if (m_cwr) begin
                    m_autoinc     = m_in[0];
                    m_addr[17:16] = m_in[2:1];
                    if (m_in[4]) m_err = 1'b0;
                end
                if (m_dwr) begin
                    busy_left = int'(W) + 2;
                    m_is_wr   = 1'b1;
                    m_wd      = m_in;
                end else if ((m_cwr && m_in[3]) || (m_drd && m_autoinc)) begin
                    busy_left = int'(W) + 1;
                    m_is_wr   = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model
    always @(negedge clk) begin
        if (started) begin
            check("ncs", 32'(sram_ncs), 32'(busy_left == 0));
            check("sram_a", 32'(sram_a), 32'(m_addr));
            if (!bus_if.sel_addr && !bus_if.sel_data && !bus_if.sel_ctrl)
                check("rd_idle", 32'(bus_if.rd), 32'd0);
            else if (bus_if.sel_data)
                check("rd_data", 32'(bus_if.rd), 32'(m_rbuf));
            else if (bus_if.sel_ctrl)
                check("rd_ctrl", 32'(bus_if.rd),
                      32'({10'b0, busy_left > 0, m_err, 1'b0, m_addr[17:16], m_autoinc}));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_bus(input logic wr, input logic rds, input logic [2:0] sel, input logic [15:0] v);
        bus_if.io_wr    = wr;
        bus_if.io_rd    = rds;
        bus_if.sel_addr = sel[0];
        bus_if.sel_data = sel[1];
        bus_if.sel_ctrl = sel[2];
        bus_if.wd       = v;
    endtask

    task automatic wr_reg(input logic [2:0] sel, input logic [15:0] v);
        set_bus(1'b1, 1'b0, sel, v);
        @(posedge clk); #1;
        set_bus(1'b0, 1'b0, SEL_NONE, 16'h0);
    endtask

    task automatic rd_reg(input logic [2:0] sel, output logic [15:0] v);
        set_bus(1'b0, 1'b1, sel, 16'h0);
        @(negedge clk);
        v = bus_if.rd;
        @(posedge clk); #1;
        set_bus(1'b0, 1'b0, SEL_NONE, 16'h0);
    endtask

    task automatic wait_idle();
        logic [15:0] s;
        int n = 0;
        do begin
            rd_reg(SEL_CTRL, s);
            n++;
        end while (s[STAT_BUSY] && n < 50);
        check("busy_timeout", 32'(s[STAT_BUSY]), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] v;
        for (int i = 0; i < int'(MEM_N); i++) begin
            sram_mem[i] = 16'h0000;
            exp_mem[i]  = 16'h0000;
        end
        set_bus(1'b0, 1'b0, SEL_NONE, 16'h0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ncs", 32'(sram_ncs), 32'd1);
        check("rst_nwe", 32'(sram_nwe), 32'd1);
        check("rst_noe", 32'(sram_noe), 32'd1);
        check("rst_oe",  32'(sram_dq_oe), 32'd0);
        check("rst_dq",  32'(sram_dq_out), 32'd0);

        // 1: reset in the middle of a write pulse aborts it
        wr_reg(SEL_ADDR, 16'h0555);
        wr_reg(SEL_DATA, 16'h7777);
        @(posedge clk); #1;
        check("t1_in_pulse", 32'(sram_nwe), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t1_nwe", 32'(sram_nwe), 32'd1);
        check("t1_oe",  32'(sram_dq_oe), 32'd0);
        check("t1_ncs", 32'(sram_ncs), 32'd1);
        rd_reg(SEL_CTRL, v);
        check("t1_status", 32'(v), 32'h0000);
        check("t1_mem", 32'(sram_mem[18'h00555]), 32'h0000);

        // 2: single write with A17 set
        wr_reg(SEL_ADDR, 16'h1234);
        wr_reg(SEL_CTRL, 16'h0004);
        wr_reg(SEL_DATA, 16'hBEEF);
        wait_idle();
        check("t2_mem", 32'(sram_mem[18'h21234]), 32'hBEEF);
        check("t2_busy_len", 32'(last_run), 32'd4);
        check("t2_addr", 32'(sram_a), 32'h21234);
        rd_reg(SEL_CTRL, v);
        check("t2_status", 32'(v), 32'h0004);

        // 3: burst across the A16 boundary
        wr_reg(SEL_CTRL, 16'h0001);
        wr_reg(SEL_ADDR, 16'hFFFE);
        wr_reg(SEL_DATA, 16'h1111); wait_idle();
        wr_reg(SEL_DATA, 16'h2222); wait_idle();
        wr_reg(SEL_DATA, 16'h3333); wait_idle();
        check("t3_mem0", 32'(sram_mem[18'h0FFFE]), 32'h1111);
        check("t3_mem1", 32'(sram_mem[18'h0FFFF]), 32'h2222);
        check("t3_mem2", 32'(sram_mem[18'h10000]), 32'h3333);
        rd_reg(SEL_CTRL, v);
        check("t3_status", 32'(v), 32'h0003);

        // 4: wrap from the top of memory
        wr_reg(SEL_CTRL, 16'h0007);
        wr_reg(SEL_ADDR, 16'hFFFF);
        wr_reg(SEL_DATA, 16'hA5A5);
        wait_idle();
        check("t4_mem", 32'(sram_mem[18'h3FFFF]), 32'hA5A5);
        check("t4_addr", 32'(sram_a), 32'h00000);
        rd_reg(SEL_CTRL, v);
        check("t4_status", 32'(v), 32'h0001);

        // 5: fetch then prefetching DATA reads
        sram_mem[0] = 16'h0010; exp_mem[0] = 16'h0010;
        sram_mem[1] = 16'h0020; exp_mem[1] = 16'h0020;
        sram_mem[2] = 16'h0030; exp_mem[2] = 16'h0030;
        wr_reg(SEL_CTRL, 16'h0001);
        wr_reg(SEL_ADDR, 16'h0000);
        wr_reg(SEL_CTRL, 16'h0009);
        wait_idle();
        check("t5_read_len", 32'(last_run), 32'd3);
        rd_reg(SEL_DATA, v); check("t5_rd0", 32'(v), 32'h0010); wait_idle();
        rd_reg(SEL_DATA, v); check("t5_rd1", 32'(v), 32'h0020); wait_idle();
        rd_reg(SEL_DATA, v); check("t5_rd2", 32'(v), 32'h0030); wait_idle();
        check("t5_addr", 32'(sram_a), 32'h00004);

        // 6: collision, clear, and clear lost to a simultaneous collision
        wr_reg(SEL_DATA, 16'hCAFE);
        wr_reg(SEL_DATA, 16'hDEAD);
        wait_idle();
        check("t6_mem_ok", 32'(sram_mem[18'h00004]), 32'hCAFE);
        check("t6_mem_drop", 32'(sram_mem[18'h00005]), 32'h0000);
        rd_reg(SEL_CTRL, v);
        check("t6_err_set", 32'(v), 32'h0011);
        wr_reg(SEL_CTRL, 16'h0010);
        rd_reg(SEL_CTRL, v);
        check("t6_err_clr", 32'(v), 32'h0000);
        wr_reg(SEL_DATA, 16'h1357);
        wr_reg(SEL_CTRL, 16'h0010);
        wait_idle();
        rd_reg(SEL_CTRL, v);
        check("t6_clr_collide", 32'(v), 32'h0010);
        check("t6_mem_late", 32'(sram_mem[18'h00005]), 32'h1357);
        wr_reg(SEL_CTRL, 16'h0010);
        rd_reg(SEL_CTRL, v);
        check("t6_final", 32'(v), 32'h0000);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
